// File: rtl/interrupt_unit_if.sv
// Controller-side handshake between the multicycle controller and the interrupt unit:
// acknowledge/return strobes, mask writes, and the pending/service outputs.
interface interrupt_unit_if #(
    parameter int N_IRQ = 4
);
    logic             isInterrupted;
    logic             INA;
    logic [31:0]      PC;
    logic             RetI;
    logic             MaskWe;
    logic [N_IRQ-1:0] MaskIn;
    logic             INT;
    logic             NMI;
    logic             INTD;
    logic [31:0]      Vector;
    logic [31:0]      EPC;
    logic [2:0]       Cause;

    modport master (
        output isInterrupted, INA, PC, RetI, MaskWe, MaskIn,
        input  INT, NMI, INTD, Vector, EPC, Cause
    );

    modport slave (
        input  isInterrupted, INA, PC, RetI, MaskWe, MaskIn,
        output INT, NMI, INTD, Vector, EPC, Cause
    );
endinterface

// File: rtl/interrupt_unit.sv
// Interrupt front end: synchronises and edge-detects IRQ/NMI lines, keeps sticky pending
// state under a mask, and tracks service level with one level of NMI nesting.
module interrupt_unit #(
    parameter int          N_IRQ      = 4,
    parameter logic [31:0] INT_BASE   = 32'h0000_0080,
    parameter int          VEC_STRIDE = 8,
    parameter logic [31:0] NMI_VECTOR = 32'h0000_0040
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             nmi_in,
    interrupt_unit_if.slave  ctl
);
    typedef enum logic [1:0] {IDLE, SVC_INT, SVC_NMI} state_t;

    state_t           state_q, state_d, ret_q, ret_d;
    logic [N_IRQ:0]   s1_q, s2_q, s2d_q, rise;
    logic [N_IRQ-1:0] pend_q, pend_d, mask_q, mask_d, avail, clr;
    logic             nmi_pend_q, nmi_pend_d, nmi_clr;
    logic [31:0]      epc_q, epc_d, vec_q, vec_d, save_epc_q, save_epc_d;
    logic [2:0]       cause_q, cause_d, save_cause_q, save_cause_d, sel;
    logic             found;
    logic             int_q, int_d, nmi_q, nmi_d;

    // NMI rides in the top bit of the synchroniser so all lines share identical latency.
    assign rise  = s2_q & ~s2d_q;
    assign avail = pend_q & ~mask_q;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        clr   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (avail[i]) begin
                found  = 1'b1;
                sel    = 3'(i);
                clr    = '0;
                clr[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        epc_d        = epc_q;
        vec_d        = vec_q;
        cause_d      = cause_q;
        save_epc_d   = save_epc_q;
        save_cause_d = save_cause_q;
        nmi_clr      = 1'b0;
        pend_d       = pend_q | rise[N_IRQ-1:0];

        if (ctl.isInterrupted) begin
            if (ctl.INA) begin
                if (state_q == IDLE && found) begin
                    // A fresh edge on the bit being serviced re-arms it.
                    pend_d  = (pend_q & ~clr) | rise[N_IRQ-1:0];
                    epc_d   = ctl.PC;
                    vec_d   = INT_BASE + 32'(sel) * 32'(VEC_STRIDE);
                    cause_d = sel;
                    state_d = SVC_INT;
                end
            end else if (state_q != SVC_NMI) begin
                nmi_clr      = 1'b1;
                epc_d        = ctl.PC;
                vec_d        = NMI_VECTOR;
                ret_d        = state_q;
                save_epc_d   = epc_q;
                save_cause_d = cause_q;
                state_d      = SVC_NMI;
            end
        end else if (ctl.RetI) begin
            if (state_q == SVC_INT) begin
                state_d = IDLE;
            end else if (state_q == SVC_NMI) begin
                state_d = ret_q;
                epc_d   = save_epc_q;
                cause_d = save_cause_q;
            end
        end

        nmi_pend_d = (nmi_pend_q & ~nmi_clr) | rise[N_IRQ];
        mask_d     = ctl.MaskWe ? ctl.MaskIn : mask_q;
        // INT sees the mask currently in force; a new mask shows up one cycle after it loads.
        int_d      = (|(pend_d & ~mask_q)) && (state_d == IDLE);
        nmi_d      = nmi_pend_d && (state_d != SVC_NMI);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            s2d_q        <= '0;
            state_q      <= IDLE;
            ret_q        <= IDLE;
            pend_q       <= '0;
            nmi_pend_q   <= 1'b0;
            mask_q       <= '1;
            epc_q        <= '0;
            vec_q        <= '0;
            cause_q      <= '0;
            save_epc_q   <= '0;
            save_cause_q <= '0;
            int_q        <= 1'b0;
            nmi_q        <= 1'b0;
        end else begin
            s1_q         <= {nmi_in, irq_in};
            s2_q         <= s1_q;
            s2d_q        <= s2_q;
            state_q      <= state_d;
            ret_q        <= ret_d;
            pend_q       <= pend_d;
            nmi_pend_q   <= nmi_pend_d;
            mask_q       <= mask_d;
            epc_q        <= epc_d;
            vec_q        <= vec_d;
            cause_q      <= cause_d;
            save_epc_q   <= save_epc_d;
            save_cause_q <= save_cause_d;
            int_q        <= int_d;
            nmi_q        <= nmi_d;
        end
    end

    assign ctl.INT    = int_q;
    assign ctl.NMI    = nmi_q;
    assign ctl.INTD   = (state_q != IDLE);
    assign ctl.Vector = vec_q;
    assign ctl.EPC    = epc_q;
    assign ctl.Cause  = cause_q;
endmodule
